// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch stage: state encodings, reset vector and
// exception entry points, and small PC helpers.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_WAIT   = 2'd1,
    S_DONE   = 2'd2,
    S_CANCEL = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'hBFC0_0000;
  localparam logic [31:0] EXC_ENTRY_GENERAL = 32'hBFC0_0380;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// SRAM-like instruction read port: one request handshake (addr_ok) followed
// later by one data return (data_ok).
interface pc_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/pc_fetch.sv
// Fetch stage: owns the PC, keeps at most one instruction read in flight and
// presents the fetched instruction to IF/ID, with branch and exception redirect.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_REQ    | request for pc is on the bus (or pc misaligned: no request)
// S_WAIT   | request accepted, waiting for data_ok
// S_DONE   | data captured in instr_buf while F was stalled
// S_CANCEL | accepted request was flushed; swallow its data_ok
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallF,
  input  logic               flush_excF,
  input  logic [31:0]        exc_pcF,
  input  logic               branch_takenD,
  input  logic [31:0]        branch_targetD,
  input  logic               is_branchD,
  pc_fetch_if.master         inst,
  output logic [31:0]        pcF,
  output logic [31:0]        pc_plus4F,
  output logic [31:0]        instrF,
  output logic [31:0]        is_in_delayslot_iF,
  output logic               adelF,
  output logic               stall_reqF
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_buf_q, instr_buf_d;

  logic adel;
  logic s_req, s_wait, s_done, s_cancel;
  logic req;
  logic vld;
  logic advance;

  assign adel     = pc_misaligned(pc_q);
  assign s_req    = (state_q == S_REQ);
  assign s_wait   = (state_q == S_WAIT);
  assign s_done   = (state_q == S_DONE);
  assign s_cancel = (state_q == S_CANCEL);

  // A misaligned pc never reaches the bus; it is reported as a valid fetch with adelF.
  assign req     = s_req & ~adel;
  assign vld     = (s_wait & inst.inst_data_ok) | s_done | (s_req & adel);
  assign advance = vld & ~stallF;

  assign inst.inst_req  = req;
  assign inst.inst_addr = pc_q;

  assign pcF                = pc_q;
  assign pc_plus4F          = pc_inc(pc_q);
  assign is_in_delayslot_iF = {31'd0, is_branchD};
  assign adelF              = adel;
  assign stall_reqF         = ~vld;

  always_comb begin
    instrF = instr_buf_q;
    if (adel) begin
      instrF = 32'd0;
    end else if (s_wait) begin
      instrF = inst.inst_rdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_buf_d = instr_buf_q;

    if (flush_excF) begin
      pc_d = exc_pcF;
      // An accepted request still owes us a data_ok; it must be drained before re-requesting.
      if (s_cancel || (req && inst.inst_addr_ok) || (s_wait && !inst.inst_data_ok)) begin
        state_d = S_CANCEL;
      end else begin
        state_d = S_REQ;
      end
    end else if (advance) begin
      pc_d    = branch_takenD ? branch_targetD : pc_inc(pc_q);
      state_d = S_REQ;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req && inst.inst_addr_ok) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst.inst_data_ok) begin
            instr_buf_d = inst.inst_rdata;
            state_d     = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        S_CANCEL: begin
          if (inst.inst_data_ok) begin
            state_d = S_REQ;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      instr_buf_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_buf_q <= instr_buf_d;
    end
  end

endmodule
